// File: rtl/memory_pkg.sv
// Shared constants and response payload type for the byte-lane data memory.
// Access sizes match the dSize encoding on the data port.
package memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 3;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } dresp_t;

endpackage

// File: rtl/memory_resp_pipe.sv
// Valid+payload delay line of STAGES registers with asynchronous active-low clear.
// STAGES=0 is a plain wire; payload is expected to already be 0 whenever valid is 0.
module memory_resp_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = clk ^ rst_n;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_stages
      logic [STAGES-1:0] v_q;
      logic [W-1:0]      d_q [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= '0;
          for (int s = 0; s < STAGES; s++) d_q[s] <= '0;
        end else begin
          v_q[0] <= in_valid;
          d_q[0] <= in_data;
          for (int s = 1; s < STAGES; s++) begin
            v_q[s] <= v_q[s-1];
            d_q[s] <= d_q[s-1];
          end
        end
      end

      assign out_valid = v_q[STAGES-1];
      assign out_data  = d_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/datamemory_bytelane.sv
// Byte-addressed little-endian 32-bit memory with a word fetch port and a
// byte/half/word load-store port, lane-masked writes and configurable latency.
module datamemory_bytelane
  import memory_pkg::*;
#(
  parameter int ADDRWIDTH = 10,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 iReq,
  input  logic [ADDRWIDTH-1:0] iAddr,
  output logic                 iValid,
  output logic [31:0]          iData,
  input  logic                 dReq,
  input  logic                 dWe,
  input  logic [1:0]           dSize,
  input  logic                 dSigned,
  input  logic [ADDRWIDTH-1:0] dAddr,
  input  logic [31:0]          dWData,
  output logic                 dValid,
  output logic [31:0]          dRData,
  output logic                 dErr
);

  // Handshake: a request is accepted on every rising edge where its Req is high
  // (no ready, no backpressure); its response shows a one-cycle valid pulse
  // after edge N+LATENCY-1, in issue order, with payload forced to 0 otherwise.

  localparam int WIDX  = ADDRWIDTH - 2;
  localparam int DEPTH = 1 << WIDX;

  generate
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("datamemory_bytelane: LATENCY must be in 1..3");
    end
  endgenerate

  function automatic logic access_ok(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: access_ok = 1'b1;
      SIZE_HALF: access_ok = ~lane[0];
      SIZE_WORD: access_ok = (lane == 2'b00);
      default:   access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << lane;
      SIZE_HALF: lane_mask = 4'b0011 << lane;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicating the right-aligned store data puts it on every lane it could target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SIZE_BYTE: store_lanes = {4{wd[7:0]}};
      SIZE_HALF: store_lanes = {2{wd[15:0]}};
      default:   store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
      SIZE_HALF: load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default:   load_extract = sh;
    endcase
  endfunction

  logic [31:0]     mem [DEPTH];
  logic [WIDX-1:0] i_idx;
  logic [WIDX-1:0] d_idx;
  logic [1:0]      d_lane;
  logic            d_ok;
  logic            d_wr;
  logic [3:0]      wmask;
  logic [31:0]     wdata;
  logic [31:0]     i_rword;
  logic [31:0]     d_rword;
  logic            unused_ok;

  assign i_idx     = iAddr[ADDRWIDTH-1:2];
  assign unused_ok = ^iAddr[1:0];
  assign d_idx     = dAddr[ADDRWIDTH-1:2];
  assign d_lane    = dAddr[1:0];
  assign d_ok      = access_ok(dSize, d_lane);
  assign d_wr      = reset_n & dReq & dWe & d_ok;
  assign wmask     = d_wr ? lane_mask(dSize, d_lane) : 4'b0000;
  assign wdata     = store_lanes(dSize, dWData);
  assign i_rword   = mem[i_idx];
  assign d_rword   = mem[d_idx];

  // Storage is never reset; a same-edge fetch sees the pre-write word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) mem[d_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  logic        i_v0;
  logic [31:0] i_d0;
  logic        d_v0;
  dresp_t      d_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_v0 <= 1'b0;
      i_d0 <= '0;
      d_v0 <= 1'b0;
      d_p0 <= '0;
    end else begin
      i_v0      <= iReq;
      i_d0      <= iReq ? i_rword : 32'h0;
      d_v0      <= dReq;
      d_p0.err  <= dReq & ~d_ok;
      d_p0.data <= (dReq & ~dWe & d_ok) ? load_extract(d_rword, dSize, d_lane, dSigned) : 32'h0;
    end
  end

  dresp_t d_pout;

  memory_resp_pipe #(.W(32), .STAGES(LATENCY-1)) u_ipipe (
    .clk      (clk),
    .rst_n    (reset_n),
    .in_valid (i_v0),
    .in_data  (i_d0),
    .out_valid(iValid),
    .out_data (iData)
  );

  memory_resp_pipe #(.W($bits(dresp_t)), .STAGES(LATENCY-1)) u_dpipe (
    .clk      (clk),
    .rst_n    (reset_n),
    .in_valid (d_v0),
    .in_data  (d_p0),
    .out_valid(dValid),
    .out_data (d_pout)
  );

  assign dRData = d_pout.data;
  assign dErr   = d_pout.err;

endmodule

// File: tb/tb_datamemory_bytelane.sv
// Scoreboard bench for datamemory_bytelane: one instance at LATENCY=1 and one at
// LATENCY=3 share the same stimulus; each has its own expected queues.
module tb_datamemory_bytelane;
  import memory_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          iReq;
  logic [AW-1:0] iAddr;
  logic          dReq;
  logic          dWe;
  logic [1:0]    dSize;
  logic          dSigned;
  logic [AW-1:0] dAddr;
  logic [31:0]   dWData;

  logic          i_valid [2];
  logic [31:0]   i_data  [2];
  logic          d_valid [2];
  logic [31:0]   d_rdata [2];
  logic          d_err   [2];

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  datamemory_bytelane #(.ADDRWIDTH(AW), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .iReq(iReq), .iAddr(iAddr), .iValid(i_valid[0]), .iData(i_data[0]),
    .dReq(dReq), .dWe(dWe), .dSize(dSize), .dSigned(dSigned), .dAddr(dAddr),
    .dWData(dWData), .dValid(d_valid[0]), .dRData(d_rdata[0]), .dErr(d_err[0])
  );

  datamemory_bytelane #(.ADDRWIDTH(AW), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset_n(reset_n),
    .iReq(iReq), .iAddr(iAddr), .iValid(i_valid[1]), .iData(i_data[1]),
    .dReq(dReq), .dWe(dWe), .dSize(dSize), .dSigned(dSigned), .dAddr(dAddr),
    .dWData(dWData), .dValid(d_valid[1]), .dRData(d_rdata[1]), .dErr(d_err[1])
  );

  // scoreboard: {due_cycle[15:0], err, data} and {due_cycle[15:0], data}
  logic [48:0] d_exp_q [2][$];
  logic [47:0] i_exp_q [2][$];
  int checks   = 0;
  int failures = 0;

  function automatic int lat_of(input int p);
    return (p == 0) ? 1 : 3;
  endfunction

  // driver tasks (inputs change 1 time unit after the falling edge)
  task automatic step();
    @(negedge clk);
    #1;
    iReq = 1'b0;
    dReq = 1'b0;
  endtask

  task automatic d_set(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_data);
    dReq = 1'b1; dWe = we; dSize = size; dSigned = sgn; dAddr = addr; dWData = wd;
    if (reset_n) begin
      for (int p = 0; p < 2; p++) d_exp_q[p].push_back({16'(cyc + lat_of(p)), exp_err, exp_data});
    end
  endtask

  task automatic i_set(input logic [AW-1:0] addr, input logic [31:0] exp_data);
    iReq = 1'b1; iAddr = addr;
    if (reset_n) begin
      for (int p = 0; p < 2; p++) i_exp_q[p].push_back({16'(cyc + lat_of(p)), exp_data});
    end
  endtask

  task automatic st(input logic [1:0] size, input logic [AW-1:0] addr, input logic [31:0] wd,
                    input logic exp_err);
    d_set(1'b1, size, 1'b0, addr, wd, exp_err, 32'h0);
    step();
  endtask

  task automatic ld(input logic [1:0] size, input logic sgn, input logic [AW-1:0] addr,
                    input logic exp_err, input logic [31:0] exp_data);
    d_set(1'b0, size, sgn, addr, 32'h0, exp_err, exp_data);
    step();
  endtask

  // monitor: pops and compares whenever a DUT presents a response
  task automatic mon_d(input int p);
    logic [48:0] e;
    if (d_valid[p]) begin
      checks++;
      if (d_exp_q[p].size() == 0) begin
        failures++;
        $display("FAIL d_unexpected lat=%0d cyc=%0d got err=%b data=%h, required no response",
                 lat_of(p), cyc, d_err[p], d_rdata[p]);
      end else begin
        e = d_exp_q[p].pop_front();
        if (e[48:33] != cyc[15:0] || e[32] != d_err[p] || e[31:0] != d_rdata[p]) begin
          failures++;
          $display("FAIL d_resp lat=%0d got err=%b data=%h at cyc %0d, required err=%b data=%h at cyc %0d",
                   lat_of(p), d_err[p], d_rdata[p], cyc, e[32], e[31:0], e[48:33]);
        end
      end
    end else begin
      checks++;
      if (d_rdata[p] != 32'h0 || d_err[p] != 1'b0) begin
        failures++;
        $display("FAIL d_idle_zero lat=%0d cyc=%0d got err=%b data=%h, required 0",
                 lat_of(p), cyc, d_err[p], d_rdata[p]);
      end
      if (d_exp_q[p].size() != 0) begin
        e = d_exp_q[p][0];
        if (e[48:33] <= cyc[15:0]) begin
          checks++;
          failures++;
          void'(d_exp_q[p].pop_front());
          $display("FAIL d_missing lat=%0d cyc=%0d got no valid, required err=%b data=%h",
                   lat_of(p), cyc, e[32], e[31:0]);
        end
      end
    end
  endtask

  task automatic mon_i(input int p);
    logic [47:0] e;
    if (i_valid[p]) begin
      checks++;
      if (i_exp_q[p].size() == 0) begin
        failures++;
        $display("FAIL i_unexpected lat=%0d cyc=%0d got data=%h, required no response",
                 lat_of(p), cyc, i_data[p]);
      end else begin
        e = i_exp_q[p].pop_front();
        if (e[47:32] != cyc[15:0] || e[31:0] != i_data[p]) begin
          failures++;
          $display("FAIL i_resp lat=%0d got data=%h at cyc %0d, required data=%h at cyc %0d",
                   lat_of(p), i_data[p], cyc, e[31:0], e[47:32]);
        end
      end
    end else begin
      checks++;
      if (i_data[p] != 32'h0) begin
        failures++;
        $display("FAIL i_idle_zero lat=%0d cyc=%0d got data=%h, required 0", lat_of(p), cyc, i_data[p]);
      end
      if (i_exp_q[p].size() != 0) begin
        e = i_exp_q[p][0];
        if (e[47:32] <= cyc[15:0]) begin
          checks++;
          failures++;
          void'(i_exp_q[p].pop_front());
          $display("FAIL i_missing lat=%0d cyc=%0d got no valid, required data=%h", lat_of(p), cyc, e[31:0]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      mon_d(p);
      mon_i(p);
    end
  end

  // directed stimulus
  initial begin
    reset_n = 1'b0;
    iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0; dSize = SIZE_BYTE;
    dSigned = 1'b0; dAddr = '0; dWData = '0;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;

    st(SIZE_WORD, 10'h010, 32'hDEADBEEF, 1'b0);
    ld(SIZE_WORD, 1'b0, 10'h010, 1'b0, 32'hDEADBEEF);
    st(SIZE_BYTE, 10'h013, 32'h00000080, 1'b0);
    ld(SIZE_BYTE, 1'b1, 10'h013, 1'b0, 32'hFFFFFF80);
    ld(SIZE_BYTE, 1'b0, 10'h013, 1'b0, 32'h00000080);
    ld(SIZE_WORD, 1'b0, 10'h010, 1'b0, 32'h80ADBEEF);
    st(SIZE_HALF, 10'h011, 32'h00001234, 1'b1);
    ld(SIZE_WORD, 1'b0, 10'h010, 1'b0, 32'h80ADBEEF);
    ld(SIZE_RSVD, 1'b0, 10'h010, 1'b1, 32'h0);
    ld(SIZE_HALF, 1'b1, 10'h012, 1'b0, 32'hFFFF80AD);
    ld(SIZE_HALF, 1'b0, 10'h010, 1'b0, 32'h0000BEEF);
    ld(SIZE_HALF, 1'b1, 10'h010, 1'b0, 32'hFFFFBEEF);
    ld(SIZE_WORD, 1'b0, 10'h012, 1'b1, 32'h0);
    ld(SIZE_BYTE, 1'b1, 10'h011, 1'b0, 32'hFFFFFFBE);
    ld(SIZE_BYTE, 1'b1, 10'h012, 1'b0, 32'hFFFFFFAD);
    st(SIZE_HALF, 10'h012, 32'hAAAA5555, 1'b0);
    st(SIZE_BYTE, 10'h010, 32'hFFFFFF12, 1'b0);
    ld(SIZE_WORD, 1'b0, 10'h010, 1'b0, 32'h5555BE12);
    st(SIZE_RSVD, 10'h010, 32'h01234567, 1'b1);
    ld(SIZE_WORD, 1'b0, 10'h010, 1'b0, 32'h5555BE12);
    ld(SIZE_HALF, 1'b1, 10'h013, 1'b1, 32'h0);

    // same-edge store and fetch of one word: fetch sees the old contents
    st(SIZE_WORD, 10'h020, 32'h11112222, 1'b0);
    d_set(1'b1, SIZE_WORD, 1'b0, 10'h020, 32'hCAFEF00D, 1'b0, 32'h0);
    i_set(10'h020, 32'h11112222);
    step();
    i_set(10'h022, 32'hCAFEF00D);
    step();

    st(SIZE_WORD, 10'h000, 32'h03020100, 1'b0);
    st(SIZE_WORD, 10'h004, 32'h07060504, 1'b0);
    st(SIZE_WORD, 10'h008, 32'h0B0A0908, 1'b0);
    st(SIZE_WORD, 10'h00C, 32'h0F0E0D0C, 1'b0);

    // back-to-back on both ports
    d_set(1'b0, SIZE_WORD, 1'b0, 10'h000, 32'h0, 1'b0, 32'h03020100); i_set(10'h00C, 32'h0F0E0D0C); step();
    d_set(1'b0, SIZE_WORD, 1'b0, 10'h004, 32'h0, 1'b0, 32'h07060504); i_set(10'h008, 32'h0B0A0908); step();
    d_set(1'b0, SIZE_WORD, 1'b0, 10'h008, 32'h0, 1'b0, 32'h0B0A0908); i_set(10'h004, 32'h07060504); step();
    d_set(1'b0, SIZE_WORD, 1'b0, 10'h00C, 32'h0, 1'b0, 32'h0F0E0D0C); i_set(10'h010, 32'h5555BE12); step();
    ld(SIZE_BYTE, 1'b0, 10'h00E, 1'b0, 32'h0000000E);
    ld(SIZE_HALF, 1'b1, 10'h00A, 1'b0, 32'h00000B0A);
    repeat (4) step();

    // reset with two loads in flight in the 3-cycle instance
    d_set(1'b0, SIZE_WORD, 1'b0, 10'h000, 32'h0, 1'b0, 32'h03020100); step();
    d_set(1'b0, SIZE_WORD, 1'b0, 10'h004, 32'h0, 1'b0, 32'h07060504); step();
    reset_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      while (d_exp_q[p].size() != 0 && d_exp_q[p][d_exp_q[p].size()-1][48:33] > cyc[15:0])
        void'(d_exp_q[p].pop_back());
      while (i_exp_q[p].size() != 0 && i_exp_q[p][i_exp_q[p].size()-1][47:32] > cyc[15:0])
        void'(i_exp_q[p].pop_back());
    end
    // a store and fetch issued under reset must be ignored
    d_set(1'b1, SIZE_WORD, 1'b0, 10'h004, 32'hBADBAD00, 1'b0, 32'h0);
    i_set(10'h000, 32'h0);
    step();
    reset_n = 1'b1;

    ld(SIZE_WORD, 1'b0, 10'h004, 1'b0, 32'h07060504);
    ld(SIZE_WORD, 1'b0, 10'h000, 1'b0, 32'h03020100);
    i_set(10'h010, 32'h5555BE12);
    step();

    repeat (8) step();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (d_exp_q[p].size() != 0 || i_exp_q[p].size() != 0) begin
        failures++;
        $display("FAIL drain lat=%0d got %0d data and %0d fetch responses outstanding, required 0",
                 lat_of(p), d_exp_q[p].size(), i_exp_q[p].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
